seq1011_frame_ctrl: RTL and testbench
=====================================

# seq1011_frame_ctrl

Frame sequencer for the 1011 Moore sequence detector. Accepts a frame of bytes over a valid/ready stream, serializes it MSB-first onto the detector's serial input, and holds the detector in reset whenever the byte stream stalls. On resume it replays the last three bits so that pattern state carries across stalls. It counts detector hits and reports the frame bit position of the first hit, sitting between a host/DMA byte source and one detector instance.

## Interface
- LEN_W, 8: width of frame length in bytes.
- CNT_W, 16: width of match counter; counter saturates at all-ones.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start; sampled only in IDLE, ignored otherwise.
- frame_len  in  LEN_W  frame length in bytes, sampled with start.
- in_data  in  8  byte to serialize, MSB first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted on an edge where in_valid && in_ready.
- det_x  out  1  registered serial bit to detector x.
- det_rst_n  out  1  registered active-low reset to detector.
- det_y  in  1  detector Moore output (high the cycle after the completing bit is sampled).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame end.
- match_count  out  CNT_W  matches counted in the current/last frame.
- found  out  1  at least one match in the frame.
- first_pos  out  LEN_W+3  0-based frame bit index of the bit completing the first match.

## Operation
- Reset values: state IDLE, in_ready 0, det_x 0, det_rst_n 0, busy 0, done 0, match_count 0, found 0, first_pos 0, history 000.
- IDLE:
  - det_rst_n 0.
  - start with frame_len==0 goes to DONE; counters are cleared.
  - start with frame_len!=0 goes to WAIT; clear match_count, found, first_pos, history, bit index, byte count.
- WAIT:
  - det_rst_n 0, in_ready 1.
  - On accept, latch the byte.
  - If it is the first byte of the frame, go to SHIFT.
  - Otherwise go to REPLAY.
- REPLAY:
  - 3 cycles; det_rst_n 1; det_x = hist[2], hist[1], hist[0] (oldest first).
  - These bits are not counted, and det_y is ignored in the cycle following each of them.
  - Then go to SHIFT.
  - Replay from S0 reconstructs an equivalent detector state: S4 transitions equal S1's, and three bits cannot complete a match.
- SHIFT:
  - det_rst_n 1; 8 cycles present byte bits 7..0 on det_x.
  - Each presented bit shifts into the 3-bit history and increments the bit index.
  - in_ready is 1 only during the bit-0 cycle, and only if more bytes remain.
  - If a byte is accepted then, SHIFT continues next cycle with no gap and no reset.
  - If bytes remain but none is accepted, go to WAIT (detector reset, replay later).
  - After the last bit of the last byte, go to DRAIN.
- DRAIN: 1 cycle; det_rst_n 1; sample det_y for the final bit; then go to DONE.
- DONE:
  - done 1 for exactly one cycle, det_rst_n 0, then go to IDLE.
  - match_count, found and first_pos hold until the next accepted start.
- Match accounting:
  - A registered flag marks that the previous cycle presented a counted SHIFT bit.
  - When that flag is set and det_y==1: match_count += 1 (saturating).
  - On the first such hit: found is set and first_pos = that bit's index.
- Mid-operation reset: immediate return to reset values; any partial frame is discarded.

## Timing
- Start to first det_x bit: start edge → WAIT; byte-accept edge → SHIFT bit 7 on det_x.
- Bit at det_x in cycle t affects match_count at the edge ending cycle t+1.
- Back-to-back frame throughput: 8 cycles per byte.
- Each stall costs the stall length plus 3 replay cycles.
- Last SHIFT cycle → DRAIN → DONE (done high) → IDLE.
- det_rst_n is deasserted on the same edge that presents the first bit. The detector therefore samples that bit from S0.

## Test plan
- Single byte 0xB0, len 1 → match_count 1, found 1, first_pos 3, done exactly once, det_rst_n 0 after DONE.
- Overlap: single byte 0xB6 (10110110) → match_count 2, first_pos 3, second hit credited for bit 6.
- Cross-byte with stall: 0x05 then 0x80, with in_valid withheld 5 cycles between them. Required:
  - det_rst_n low during WAIT;
  - det_x replays 1,0,1 before 0x80;
  - match_count 1, first_pos 8.
- Same two bytes back-to-back with in_valid held high:
  - in_ready high in the bit-0 cycle of byte 0;
  - no WAIT/REPLAY, 16 contiguous SHIFT cycles;
  - match_count 1, first_pos 8.
- frame_len 0 → done pulse one cycle after start, match_count 0, found 0. A start during busy has no effect.
- reset low mid-SHIFT of 0xBB → all outputs at reset values. A subsequent len-1 frame of 0x0B gives match_count 1, first_pos 7.

Source files
------------

// File: rtl/seq1011_frame_ctrl_if.sv
// Stream, detector and status signals between a byte source/detector pair and the 1011 frame sequencer.
// The master side is the host plus detector; the slave side is the sequencer.
interface seq1011_frame_ctrl_if #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
);
  logic               start;
  logic [LEN_W-1:0]   frame_len;
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               det_x;
  logic               det_rst_n;
  logic               det_y;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   match_count;
  logic               found;
  logic [LEN_W+2:0]   first_pos;

  modport master (
    output start, frame_len, in_data, in_valid, det_y,
    input  in_ready, det_x, det_rst_n, busy, done, match_count, found, first_pos
  );

  modport slave (
    input  start, frame_len, in_data, in_valid, det_y,
    output in_ready, det_x, det_rst_n, busy, done, match_count, found, first_pos
  );
endinterface

// File: rtl/seq1011_frame_ctrl.sv
// Serializes a byte frame MSB-first into a 1011 detector, resets the detector across stalls and
// replays the last three bits on resume, counting hits and recording the first hit position.
module seq1011_frame_ctrl #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  seq1011_frame_ctrl_if.slave bus
);

  localparam int POS_W = LEN_W + 3;

  typedef enum logic [2:0] {IDLE, WAIT, REPLAY, SHIFT, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        shReg_q, shReg_d;
  logic [2:0]        bitPos_q, bitPos_d;
  logic [1:0]        repCnt_q, repCnt_d;
  logic [2:0]        hist_q, hist_d;
  logic [POS_W-1:0]  bitIdx_q, bitIdx_d;
  logic [LEN_W-1:0]  bytesLeft_q, bytesLeft_d;
  logic              detX_q, detX_d;
  logic              detRstN_q, detRstN_d;
  logic              counted_q, counted_d;
  logic [CNT_W-1:0]  matchCount_q, matchCount_d;
  logic              found_q, found_d;
  logic [POS_W-1:0]  firstPos_q, firstPos_d;
  logic              inReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shReg_q      <= '0;
      bitPos_q     <= '0;
      repCnt_q     <= '0;
      hist_q       <= '0;
      bitIdx_q     <= '0;
      bytesLeft_q  <= '0;
      detX_q       <= 1'b0;
      detRstN_q    <= 1'b0;
      counted_q    <= 1'b0;
      matchCount_q <= '0;
      found_q      <= 1'b0;
      firstPos_q   <= '0;
    end else begin
      state_q      <= state_d;
      shReg_q      <= shReg_d;
      bitPos_q     <= bitPos_d;
      repCnt_q     <= repCnt_d;
      hist_q       <= hist_d;
      bitIdx_q     <= bitIdx_d;
      bytesLeft_q  <= bytesLeft_d;
      detX_q       <= detX_d;
      detRstN_q    <= detRstN_d;
      counted_q    <= counted_d;
      matchCount_q <= matchCount_d;
      found_q      <= found_d;
      firstPos_q   <= firstPos_d;
    end
  end

  // shReg_q holds the not-yet-presented bits of the current byte, left-aligned.
  always_comb begin
    state_d      = state_q;
    shReg_d      = shReg_q;
    bitPos_d     = bitPos_q;
    repCnt_d     = repCnt_q;
    hist_d       = hist_q;
    bitIdx_d     = bitIdx_q;
    bytesLeft_d  = bytesLeft_q;
    detX_d       = detX_q;
    detRstN_d    = detRstN_q;
    counted_d    = 1'b0;
    matchCount_d = matchCount_q;
    found_d      = found_q;
    firstPos_d   = firstPos_q;
    inReady      = 1'b0;

    case (state_q)
      IDLE: begin
        detRstN_d = 1'b0;
        detX_d    = 1'b0;
        if (bus.start) begin
          matchCount_d = '0;
          found_d      = 1'b0;
          firstPos_d   = '0;
          hist_d       = '0;
          bitIdx_d     = '0;
          bytesLeft_d  = bus.frame_len;
          state_d      = (bus.frame_len == '0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          bytesLeft_d = bytesLeft_q - LEN_W'(1);
          detRstN_d   = 1'b1;
          // No bits presented yet means this is the first byte: nothing to replay.
          if (bitIdx_q == '0) begin
            detX_d   = bus.in_data[7];
            shReg_d  = {bus.in_data[6:0], 1'b0};
            bitPos_d = 3'd7;
            state_d  = SHIFT;
          end else begin
            detX_d   = hist_q[2];
            shReg_d  = bus.in_data;
            repCnt_d = 2'd0;
            state_d  = REPLAY;
          end
        end
      end
      REPLAY: begin
        repCnt_d = repCnt_q + 2'd1;
        case (repCnt_q)
          2'd0:    detX_d = hist_q[1];
          2'd1:    detX_d = hist_q[0];
          default: begin
            detX_d   = shReg_q[7];
            shReg_d  = {shReg_q[6:0], 1'b0};
            bitPos_d = 3'd7;
            state_d  = SHIFT;
          end
        endcase
      end
      SHIFT: begin
        counted_d = 1'b1;
        hist_d    = {hist_q[1:0], detX_q};
        bitIdx_d  = bitIdx_q + POS_W'(1);
        if (bitPos_q != 3'd0) begin
          detX_d   = shReg_q[7];
          shReg_d  = {shReg_q[6:0], 1'b0};
          bitPos_d = bitPos_q - 3'd1;
        end else if (bytesLeft_q != '0) begin
          inReady = 1'b1;
          if (bus.in_valid) begin
            bytesLeft_d = bytesLeft_q - LEN_W'(1);
            detX_d      = bus.in_data[7];
            shReg_d     = {bus.in_data[6:0], 1'b0};
            bitPos_d    = 3'd7;
          end else begin
            detRstN_d = 1'b0;
            detX_d    = 1'b0;
            state_d   = WAIT;
          end
        end else begin
          detX_d  = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        detRstN_d = 1'b0;
        detX_d    = 1'b0;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // det_y in this cycle answers the bit presented last cycle, whose index is bitIdx_q-1.
    if (counted_q && bus.det_y) begin
      if (matchCount_q != '1) begin
        matchCount_d = matchCount_q + CNT_W'(1);
      end
      if (!found_q) begin
        found_d    = 1'b1;
        firstPos_d = bitIdx_q - POS_W'(1);
      end
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.det_x       = detX_q;
  assign bus.det_rst_n   = detRstN_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.match_count = matchCount_q;
  assign bus.found       = found_q;
  assign bus.first_pos   = firstPos_q;

endmodule

// File: tb/tb_seq1011_frame_ctrl.sv
// Directed bench for seq1011_frame_ctrl with a behavioural 1011 Moore detector attached to det_x/det_y.
module tb_seq1011_frame_ctrl;

  localparam int LEN_W = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq1011_frame_ctrl_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq1011_frame_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference 1011 Moore detector: output high while in D4.
  typedef enum logic [2:0] {D0, D1, D2, D3, D4} det_t;
  det_t detState;

  always_ff @(posedge clk or negedge bus.det_rst_n) begin
    if (!bus.det_rst_n) detState <= D0;
    else begin
      case (detState)
        D0:      detState <= bus.det_x ? D1 : D0;
        D1:      detState <= bus.det_x ? D1 : D2;
        D2:      detState <= bus.det_x ? D3 : D0;
        D3:      detState <= bus.det_x ? D4 : D2;
        D4:      detState <= bus.det_x ? D1 : D2;
        default: detState <= D0;
      endcase
    end
  end

  assign bus.det_y = (detState == D4);

  typedef struct packed {
    logic rstn;
    logic x;
    logic rdy;
  } mon_t;

  mon_t monQ[$];
  int   doneCnt;
  int   total = 0;
  int   bad = 0;

  always @(negedge clk) begin
    if (bus.busy) monQ.push_back('{rstn: bus.det_rst_n, x: bus.det_x, rdy: bus.in_ready});
    if (bus.done) doneCnt++;
  end

  typedef struct {
    logic [7:0] data;
    int         expCount;
    logic       expFound;
    int         expFirst;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic pushByte(input logic [7:0] d);
    int n;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("acceptReady", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDone(output int waited);
    waited = 0;
    while (!bus.done && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("doneSeen", 32'(bus.done), 32'd1);
    @(negedge clk);
  endtask

  // Runs a frame of up to two bytes; gap is the number of idle negedges between byte pushes.
  task automatic applyStimulus(input logic [LEN_W-1:0] len, input logic [7:0] b0,
                               input logic [7:0] b1, input int gap, output int waited);
    monQ.delete();
    doneCnt = 0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.frame_len = len;
    @(negedge clk);
    bus.start = 1'b0;
    if (len >= 1) pushByte(b0);
    if (len >= 2) begin
      repeat (gap) @(negedge clk);
      pushByte(b1);
    end
    waitDone(waited);
  endtask

  task automatic analyzeLog(output int hiCnt, output logic [31:0] hiBits,
                            output int lowsBetween, output logic rdyAt8);
    int pending;
    logic seenHigh;
    hiCnt = 0; hiBits = '0; lowsBetween = 0; rdyAt8 = 1'b0;
    pending = 0; seenHigh = 1'b0;
    foreach (monQ[i]) begin
      if (monQ[i].rstn) begin
        hiBits = {hiBits[30:0], monQ[i].x};
        hiCnt++;
        if (hiCnt == 8) rdyAt8 = monQ[i].rdy;
        lowsBetween += pending;
        pending = 0;
        seenHigh = 1'b1;
      end else if (seenHigh) begin
        pending++;
      end
    end
  endtask

  initial begin
    int waited, hiCnt, lowsBetween;
    logic [31:0] hiBits;
    logic rdyAt8;

    vecs[0] = '{8'h00, 0, 1'b0, 0};
    vecs[1] = '{8'hFF, 0, 1'b0, 0};
    vecs[2] = '{8'hB0, 1, 1'b1, 3};
    vecs[3] = '{8'hB6, 2, 1'b1, 3};
    vecs[4] = '{8'h2D, 1, 1'b1, 5};
    vecs[5] = '{8'h0B, 1, 1'b1, 7};
    vecs[6] = '{8'hDB, 2, 1'b1, 4};

    bus.start = 1'b0; bus.frame_len = '0; bus.in_data = '0; bus.in_valid = 1'b0;
    doneCnt = 0;

    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstDetRstN", 32'(bus.det_rst_n), 32'd0);
    checkOutput("rstReady", 32'(bus.in_ready), 32'd0);
    checkOutput("rstCount", 32'(bus.match_count), 32'd0);
    rst_n = 1'b1;

    $display("[TB] single-byte table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(8'd1, vecs[i].data, 8'h00, 0, waited);
      checkOutput($sformatf("count[%0h]", vecs[i].data), 32'(bus.match_count), 32'(vecs[i].expCount));
      checkOutput($sformatf("found[%0h]", vecs[i].data), 32'(bus.found), 32'(vecs[i].expFound));
      checkOutput($sformatf("first[%0h]", vecs[i].data), 32'(bus.first_pos), 32'(vecs[i].expFirst));
      checkOutput($sformatf("doneCnt[%0h]", vecs[i].data), 32'(doneCnt), 32'd1);
      checkOutput($sformatf("idleRst[%0h]", vecs[i].data), 32'(bus.det_rst_n), 32'd0);
      checkOutput($sformatf("idleBusy[%0h]", vecs[i].data), 32'(bus.busy), 32'd0);
    end

    $display("[TB] cross-byte with stall");
    applyStimulus(8'd2, 8'h05, 8'h80, 12, waited);
    analyzeLog(hiCnt, hiBits, lowsBetween, rdyAt8);
    checkOutput("stallHiCnt", 32'(hiCnt), 32'd20);
    checkOutput("stallBits", hiBits, 32'h0005B00);
    checkOutput("stallLows", 32'(lowsBetween), 32'd5);
    checkOutput("stallCount", 32'(bus.match_count), 32'd1);
    checkOutput("stallFirst", 32'(bus.first_pos), 32'd8);

    $display("[TB] cross-byte back-to-back");
    applyStimulus(8'd2, 8'h05, 8'h80, 0, waited);
    analyzeLog(hiCnt, hiBits, lowsBetween, rdyAt8);
    checkOutput("b2bHiCnt", 32'(hiCnt), 32'd17);
    checkOutput("b2bBits", hiBits, 32'h00000B00);
    checkOutput("b2bLows", 32'(lowsBetween), 32'd0);
    checkOutput("b2bReadyBit0", 32'(rdyAt8), 32'd1);
    checkOutput("b2bCount", 32'(bus.match_count), 32'd1);
    checkOutput("b2bFirst", 32'(bus.first_pos), 32'd8);

    $display("[TB] zero-length frame");
    applyStimulus(8'd0, 8'h00, 8'h00, 0, waited);
    checkOutput("len0Latency", 32'(waited), 32'd0);
    checkOutput("len0DoneCnt", 32'(doneCnt), 32'd1);
    checkOutput("len0Count", 32'(bus.match_count), 32'd0);
    checkOutput("len0Found", 32'(bus.found), 32'd0);

    $display("[TB] start while busy");
    monQ.delete();
    doneCnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.frame_len = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    pushByte(8'hB0);
    bus.start = 1'b1; bus.frame_len = 8'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.frame_len = 8'd1;
    waitDone(waited);
    checkOutput("busyStartCount", 32'(bus.match_count), 32'd1);
    checkOutput("busyStartFirst", 32'(bus.first_pos), 32'd3);
    checkOutput("busyStartDone", 32'(doneCnt), 32'd1);

    $display("[TB] reset mid-shift");
    @(negedge clk);
    bus.start = 1'b1; bus.frame_len = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    pushByte(8'hBB);
    repeat (5) @(negedge clk);
    checkOutput("midShiftBusy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstReady", 32'(bus.in_ready), 32'd0);
    checkOutput("midRstDetX", 32'(bus.det_x), 32'd0);
    checkOutput("midRstDetRstN", 32'(bus.det_rst_n), 32'd0);
    checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
    checkOutput("midRstDone", 32'(bus.done), 32'd0);
    checkOutput("midRstCount", 32'(bus.match_count), 32'd0);
    checkOutput("midRstFound", 32'(bus.found), 32'd0);
    checkOutput("midRstFirst", 32'(bus.first_pos), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'd1, 8'h0B, 8'h00, 0, waited);
    checkOutput("postRstCount", 32'(bus.match_count), 32'd1);
    checkOutput("postRstFound", 32'(bus.found), 32'd1);
    checkOutput("postRstFirst", 32'(bus.first_pos), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
